vram_arbiter: RTL
=================

// Module: vram_arbiter
// PURPOSE
//  Shares one single-port video SRAM between the CPU bus and the videocrt
//  fetch port (VAD/vram_cs/VDI/vram_complete). Video fetches have fixed
//  priority. The CPU gets the SRAM whenever no video fetch is pending.
//  Sits between videocrt, the CPU address decoder and the external SRAM pins.
// PARAMETERS
//  WAIT_STATES  1  extra SRAM cycles per access (0..7); access = WAIT_STATES+1 cycles
// PORTS
//  clk            in   1   system clock, same clock domain as videocrt clk
//  rst            in   1   synchronous reset, active-high
//  vid_addr       in   16  video fetch address (videocrt VAD)
//  vid_cs         in   1   video request, level, held until vid_complete
//  vid_data       out  8   video read data (videocrt VDI)
//  vid_complete   out  1   one-cycle pulse, vid_data valid in the same cycle
//  cpu_addr       in   16  CPU address
//  cpu_di         in   8   CPU write data
//  cpu_do         out  8   CPU read data, held until the next CPU read completes
//  cpu_rw         in   1   1=read, 0=write; sampled at grant
//  cpu_cs         in   1   CPU request, level, held until cpu_ready
//  cpu_ready      out  1   one-cycle pulse, access done (cpu_do valid on a read)
//  mem_addr       out  16  SRAM address
//  mem_wdata      out  8   SRAM write data
//  mem_rdata      in   8   SRAM read data, valid by the last access cycle
//  mem_ce         out  1   SRAM chip enable, active-high
//  mem_oe         out  1   SRAM output enable, active-high
//  mem_we         out  1   SRAM write enable, active-high
// BEHAVIOUR
//  Reset: all outputs are registered and reset to 0; state=IDLE; vid_arm=cpu_arm=1.
//  Reset mid-access aborts the access: strobes drop, no complete/ready pulse is issued.
//  States: IDLE, ACCESS (owner = VID or CPU; op = RD or WR), DONE.
//  Arm flags:
//   - A port is eligible only when its cs=1 and its arm=1.
//   - arm clears at grant. arm sets again on any cycle where that port's cs=0.
//   - Effect: a cs still high in the cycle after complete/ready does not start a new access.
//  IDLE:
//   - If video is eligible, grant VID. Else if CPU is eligible, grant CPU. Else stay in IDLE.
//   - At the grant edge:
//     - mem_addr <= the owner's address; mem_ce <= 1.
//     - RD: mem_oe <= 1.
//     - WR: mem_we <= 1 and mem_wdata <= cpu_di.
//     - cnt <= WAIT_STATES; next state is ACCESS.
//   - Video is always RD.
//  ACCESS:
//   - While cnt != 0, decrement cnt; mem_addr, mem_wdata and the strobes hold.
//   - When cnt == 0, at that edge:
//     - mem_ce, mem_oe and mem_we <= 0.
//     - RD: latch mem_rdata into vid_data or cpu_do.
//     - Pulse vid_complete or cpu_ready (high for exactly one cycle).
//     - Next state is DONE.
//  DONE: one turnaround cycle with no strobes, then IDLE. Guarantees a >= 1 cycle bus gap.
//  Timing: a request sampled at edge E0 gives its complete/ready pulse after edge
//   E0+WAIT_STATES+1. Back-to-back grant interval = WAIT_STATES+3 cycles.
//  Simultaneous requests in IDLE: VID wins; CPU waits with cpu_cs held.
//  A request that arrives during another owner's access waits. No request is dropped.
//  Requests are never pre-empted. A VID request arriving mid-CPU access waits for DONE.
//  cs dropped before grant: the request is withdrawn. No access and no pulse.
//  cs dropped after grant: the access still completes and the pulse is still issued.
//  vid_data and cpu_do hold their last value between reads. mem_wdata holds after a write.
//  No address arithmetic is done: addresses pass unmodified, 16 bits.
// TESTING
//  1 Reset release, no cs -> all mem strobes 0, no pulses for 20 cycles.
//  2 WS=1, cpu write 0x1234<-0xA5 then cpu read 0x1234:
//    - write: mem_we high 2 cycles, then one cpu_ready pulse
//    - read: cpu_do=0xA5 with cpu_ready 2 cycles after the grant edge
//  3 vid_cs and cpu_cs asserted in the same cycle:
//    - video access to VAD=0x8000 is granted first
//    - CPU grant follows after the DONE cycle; each side gets exactly one pulse
//  4 vid_cs held high 1 cycle past vid_complete (videocrt style) -> exactly one access, no re-fetch.
//  5 rst asserted in the middle of ACCESS -> strobes 0 after the next edge, no pulse, state IDLE.
//  6 WS=0 and WS=7 sweep, 100 random mixed requests vs SRAM model:
//    - every read returns the last written data
//    - latency = WS+1 edges after grant

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port video SRAM between the video fetch
// port and the CPU bus. Video has fixed priority; accesses are never
// pre-empted and are followed by one turnaround cycle with no strobes.
module vram_arbiter #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] vid_addr,
  input  logic        vid_cs,
  output logic [7:0]  vid_data,
  output logic        vid_complete,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_di,
  output logic [7:0]  cpu_do,
  input  logic        cpu_rw,
  input  logic        cpu_cs,
  output logic        cpu_ready,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_ce,
  output logic        mem_oe,
  output logic        mem_we
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(WAIT_STATES);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_cnt;
  logic        r_vid_arm;
  logic        r_cpu_arm;
  logic        r_own_vid;
  logic        r_op_rd;

  logic [7:0]  r_vid_data;
  logic        r_vid_complete;
  logic [7:0]  r_cpu_do;
  logic        r_cpu_ready;
  logic [15:0] r_mem_addr;
  logic [7:0]  r_mem_wdata;
  logic        r_mem_ce;
  logic        r_mem_oe;
  logic        r_mem_we;

  logic        w_vid_elig;
  logic        w_cpu_elig;
  logic        w_grant_vid;
  logic        w_grant_cpu;
  logic        w_finish;

  // A port may only be granted after it has dropped cs since its last grant.
  assign w_vid_elig = vid_cs & r_vid_arm;
  assign w_cpu_elig = cpu_cs & r_cpu_arm;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic and grant/finish decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_vid = 1'b0;
    w_grant_cpu = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_vid_elig) begin
          w_grant_vid = 1'b1;
          w_state_nxt = ST_ACCESS;
        end else if (w_cpu_elig) begin
          w_grant_cpu = 1'b1;
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (r_cnt == 3'd0) begin
          w_finish    = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Arm flags: clear at grant, re-arm on any cycle with cs low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vid_arm <= 1'b1;
      r_cpu_arm <= 1'b1;
    end else begin
      if (w_grant_vid)  r_vid_arm <= 1'b0;
      else if (!vid_cs) r_vid_arm <= 1'b1;
      if (w_grant_cpu)  r_cpu_arm <= 1'b0;
      else if (!cpu_cs) r_cpu_arm <= 1'b1;
    end
  end

  // SRAM pin drive, wait-state counter, read-data capture and done pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_own_vid      <= 1'b0;
      r_op_rd        <= 1'b0;
      r_vid_data     <= '0;
      r_vid_complete <= 1'b0;
      r_cpu_do       <= '0;
      r_cpu_ready    <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_mem_ce       <= 1'b0;
      r_mem_oe       <= 1'b0;
      r_mem_we       <= 1'b0;
    end else begin
      r_vid_complete <= 1'b0;
      r_cpu_ready    <= 1'b0;
      if (w_grant_vid || w_grant_cpu) begin
        r_own_vid  <= w_grant_vid;
        r_op_rd    <= w_grant_vid | cpu_rw;
        r_mem_addr <= w_grant_vid ? vid_addr : cpu_addr;
        r_mem_ce   <= 1'b1;
        r_mem_oe   <= w_grant_vid | cpu_rw;
        r_mem_we   <= w_grant_cpu & ~cpu_rw;
        if (w_grant_cpu && !cpu_rw) r_mem_wdata <= cpu_di;
        r_cnt      <= CNT_INIT;
      end else if (r_state == ST_ACCESS) begin
        if (w_finish) begin
          r_mem_ce <= 1'b0;
          r_mem_oe <= 1'b0;
          r_mem_we <= 1'b0;
          if (r_own_vid) begin
            r_vid_complete <= 1'b1;
            if (r_op_rd) r_vid_data <= mem_rdata;
          end else begin
            r_cpu_ready <= 1'b1;
            if (r_op_rd) r_cpu_do <= mem_rdata;
          end
        end else begin
          r_cnt <= r_cnt - 3'd1;
        end
      end
    end
  end

  assign vid_data     = r_vid_data;
  assign vid_complete = r_vid_complete;
  assign cpu_do       = r_cpu_do;
  assign cpu_ready    = r_cpu_ready;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign mem_ce       = r_mem_ce;
  assign mem_oe       = r_mem_oe;
  assign mem_we       = r_mem_we;

endmodule
